// File: rtl/humidity_frame_decoder.sv
// Checksums each completed DHT frame and publishes scaled hum/temp with staleness and fan hysteresis; DHT22_FMT_EN selects DHT22 decoding (default DHT11).
// Latency: 3 clk1M cycles from the edge that first samples mstate==3 to new_sample/crc_err and updated outputs.
// Backpressure: none; reader frame spacing keeps the pipeline idle, so a frame_done arriving mid-decode is dropped.
module humidity_frame_decoder #(
    parameter int unsigned HUM_ON      = 700,
    parameter int unsigned HUM_OFF     = 600,
    parameter int unsigned STALE_TICKS = 15000000
) (
    input  logic        clk1M,
    input  logic        rst_n,
    input  logic [39:0] HYM2,
    input  logic [2:0]  mstate,
    output logic [15:0] hum_out,
    output logic [15:0] temp_out,
    output logic        new_sample,
    output logic        crc_err,
    output logic [7:0]  err_cnt,
    output logic        data_valid,
    output logic        stale,
    output logic        fan_on
);

    localparam int                TMR_W      = $clog2(STALE_TICKS + 1);
    localparam logic [TMR_W-1:0]  STALE_MAX  = TMR_W'(STALE_TICKS);
    localparam logic [TMR_W-1:0]  STALE_LAST = TMR_W'(STALE_TICKS - 1);
    localparam logic [15:0]       HUM_ON_V   = 16'(HUM_ON);
    localparam logic [15:0]       HUM_OFF_V  = 16'(HUM_OFF);
    localparam logic [2:0]        MST_DONE   = 3'd3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        CHECK   = 2'd2,
        UPDATE  = 2'd3
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [2:0]         mstate_q;
    logic               frame_done;
    logic [39:0]        frame_r;
    logic [7:0]         sum8;
    logic               frame_ok;
    logic               ok_r;
    logic [15:0]        hum_dec;
    logic [15:0]        temp_dec;
    logic [15:0]        hum_r;
    logic [15:0]        temp_r;
    logic               valid_upd;
    logic               bad_upd;
    logic               stale_hit;
    logic [TMR_W-1:0]   stale_tmr;

    assign frame_done = (mstate == MST_DONE) && (mstate_q != MST_DONE);

    // Byte sum wraps naturally in 8 bits; an all-zero frame means no sensor answered.
    assign sum8     = frame_r[39:32] + frame_r[31:24] + frame_r[23:16] + frame_r[15:8];
    assign frame_ok = (sum8 == frame_r[7:0]) && (frame_r != 40'h0);

`ifdef DHT22_FMT_EN
    logic [15:0] temp_mag;
    assign temp_mag = {1'b0, frame_r[22:16], frame_r[15:8]};
    assign hum_dec  = frame_r[39:24];
    assign temp_dec = frame_r[23] ? (16'd0 - temp_mag) : temp_mag;
`else
    assign hum_dec  = {8'd0, frame_r[39:32]} * 16'd10;
    assign temp_dec = {8'd0, frame_r[23:16]} * 16'd10;
`endif

    assign valid_upd = (state == UPDATE) && ok_r;
    assign bad_upd   = (state == UPDATE) && !ok_r;
    assign stale_hit = !valid_upd && (stale_tmr == STALE_LAST);

    always_ff @(posedge clk1M or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            mstate_q <= 3'd0;
        end else begin
            state    <= state_nxt;
            mstate_q <= mstate;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (frame_done) state_nxt = CAPTURE;
            CAPTURE: state_nxt = CHECK;
            CHECK:   state_nxt = UPDATE;
            UPDATE:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Decode pipeline: capture, checksum, scale, then commit in UPDATE.
    always_ff @(posedge clk1M or negedge rst_n) begin
        if (!rst_n) begin
            frame_r <= 40'h0;
            ok_r    <= 1'b0;
            hum_r   <= 16'd0;
            temp_r  <= 16'd0;
        end else begin
            if (state == IDLE && frame_done) frame_r <= HYM2;
            if (state == CAPTURE)            ok_r    <= frame_ok;
            if (state == CHECK) begin
                hum_r  <= hum_dec;
                temp_r <= temp_dec;
            end
        end
    end

    always_ff @(posedge clk1M or negedge rst_n) begin
        if (!rst_n) begin
            stale_tmr <= '0;
        end else if (valid_upd) begin
            stale_tmr <= '0;
        end else if (stale_tmr != STALE_MAX) begin
            stale_tmr <= stale_tmr + 1'b1;
        end
    end

    always_ff @(posedge clk1M or negedge rst_n) begin
        if (!rst_n) begin
            hum_out    <= 16'd0;
            temp_out   <= 16'd0;
            new_sample <= 1'b0;
            crc_err    <= 1'b0;
            err_cnt    <= 8'd0;
            data_valid <= 1'b0;
            stale      <= 1'b1;
            fan_on     <= 1'b0;
        end else begin
            new_sample <= valid_upd;
            crc_err    <= bad_upd;
            if (valid_upd) begin
                hum_out    <= hum_r;
                temp_out   <= temp_r;
                data_valid <= 1'b1;
                stale      <= 1'b0;
                // Between the thresholds the previous request is held.
                if (hum_r >= HUM_ON_V) begin
                    fan_on <= 1'b1;
                end else if (hum_r <= HUM_OFF_V) begin
                    fan_on <= 1'b0;
                end
            end else if (stale_hit) begin
                stale      <= 1'b1;
                data_valid <= 1'b0;
                fan_on     <= 1'b0;
            end
            if (bad_upd && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_humidity_frame_decoder.sv
// Randomised and directed frames against a behavioural model of the decoder.
module tb_humidity_frame_decoder;

    localparam int STALE = 100;

    logic        clk1M = 1'b0;
    logic        rst_n;
    logic [39:0] HYM2;
    logic [2:0]  mstate;
    logic [15:0] hum_out;
    logic [15:0] temp_out;
    logic        new_sample;
    logic        crc_err;
    logic [7:0]  err_cnt;
    logic        data_valid;
    logic        stale;
    logic        fan_on;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    int m_hum;
    int m_temp;
    int m_err;
    bit m_fan;
    bit m_ever;
    int m_vcyc;

    humidity_frame_decoder #(.STALE_TICKS(STALE)) dut (
        .clk1M(clk1M), .rst_n(rst_n), .HYM2(HYM2), .mstate(mstate),
        .hum_out(hum_out), .temp_out(temp_out), .new_sample(new_sample),
        .crc_err(crc_err), .err_cnt(err_cnt), .data_valid(data_valid),
        .stale(stale), .fan_on(fan_on)
    );

    always #500 clk1M = ~clk1M;
    always @(posedge clk1M) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic bit ref_ok(input logic [39:0] f);
        int s;
        s = int'(f[39:32]) + int'(f[31:24]) + int'(f[23:16]) + int'(f[15:8]);
        return ((s % 256) == int'(f[7:0])) && (f != 40'h0);
    endfunction

    function automatic int ref_hum(input logic [39:0] f);
`ifdef DHT22_FMT_EN
        return int'(f[39:32]) * 256 + int'(f[31:24]);
`else
        return int'(f[39:32]) * 10;
`endif
    endfunction

    function automatic int ref_temp(input logic [39:0] f);
`ifdef DHT22_FMT_EN
        int mag;
        mag = int'(f[22:16]) * 256 + int'(f[15:8]);
        return f[23] ? -mag : mag;
`else
        return int'(f[23:16]) * 10;
`endif
    endfunction

    function automatic bit exp_stale();
        return !m_ever || ((cyc - m_vcyc) >= STALE);
    endfunction

    task automatic model_reset();
        m_hum = 0; m_temp = 0; m_err = 0; m_fan = 0; m_ever = 0; m_vcyc = 0;
    endtask

    task automatic model_frame(input logic [39:0] f, input int cu);
        int h;
        if (m_ever && (cu - m_vcyc) > STALE) m_fan = 0;
        if (ref_ok(f)) begin
            h      = ref_hum(f);
            m_hum  = h;
            m_temp = ref_temp(f);
            if (h >= 700)      m_fan = 1;
            else if (h <= 600) m_fan = 0;
            m_ever = 1;
            m_vcyc = cu;
        end else if (m_err < 255) begin
            m_err++;
        end
    endtask

    task automatic check_status(input string tag);
        bit s;
        int tt;
        s  = exp_stale();
        tt = m_temp;
        check_val({tag, "_stale"}, 32'(stale), 32'(s));
        check_val({tag, "_valid"}, 32'(data_valid), 32'(!s));
        check_val({tag, "_fan"},   32'(fan_on), 32'(s ? 1'b0 : m_fan));
        check_val({tag, "_hum"},   32'(hum_out), 32'(m_hum));
        check_val({tag, "_temp"},  32'(temp_out), 32'(tt[15:0]));
        check_val({tag, "_err"},   32'(err_cnt), 32'(m_err));
    endtask

    task automatic send_frame(input logic [39:0] f, input string tag);
        bit ok;
        @(negedge clk1M);
        HYM2   = f;
        mstate = 3'd3;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk1M);
            check_val({tag, "_early"}, {30'd0, new_sample, crc_err}, 32'd0);
        end
        @(negedge clk1M);
        ok = ref_ok(f);
        model_frame(f, cyc);
        check_val({tag, "_pulse"}, {30'd0, new_sample, crc_err}, {30'd0, ok, !ok});
        check_status(tag);
        mstate = 3'd2;
        @(negedge clk1M);
        check_val({tag, "_pulse1"}, {30'd0, new_sample, crc_err}, 32'd0);
    endtask

    task automatic idle_chk(input int n);
        repeat (n) begin
            @(negedge clk1M);
            check_val("idle_pulse", {30'd0, new_sample, crc_err}, 32'd0);
            check_status("idle");
        end
    endtask

    task automatic reset_now(input string tag);
        #100;
        rst_n  = 1'b0;
        mstate = 3'd0;
        model_reset();
        #1;
        check_val({tag, "_pulse"}, {30'd0, new_sample, crc_err}, 32'd0);
        check_status(tag);
        @(negedge clk1M);
        rst_n = 1'b1;
    endtask

    function automatic logic [39:0] rand_frame();
        logic [7:0] b4, b3, b2, b1, cs;
        int s;
`ifdef DHT22_FMT_EN
        int h, t;
        h  = $urandom_range(500, 800);
        t  = $urandom_range(0, 800);
        b4 = 8'(h >> 8);
        b3 = 8'(h);
        b2 = {1'($urandom_range(0, 1)), 7'(t >> 8)};
        b1 = 8'(t);
`else
        b4 = 8'($urandom_range(50, 80));
        b3 = 8'($urandom_range(0, 9));
        b2 = 8'($urandom_range(0, 50));
        b1 = 8'($urandom_range(0, 9));
`endif
        s  = int'(b4) + int'(b3) + int'(b2) + int'(b1);
        if ($urandom_range(0, 3) == 0) s = s + int'($urandom_range(1, 255));
        cs = 8'(s);
        return {b4, b3, b2, b1, cs};
    endfunction

    initial begin
        rst_n  = 1'b0;
        HYM2   = 40'h0;
        mstate = 3'd0;
        model_reset();
        repeat (3) @(negedge clk1M);
        check_val("rst_pulse", {30'd0, new_sample, crc_err}, 32'd0);
        check_status("rst");
        rst_n = 1'b1;
        idle_chk(3);

        send_frame(40'h2D00170044, "good1");
        idle_chk(2);
        send_frame(40'h2D00170045, "badcs");
        send_frame(40'h0000000000, "zero");
        send_frame(40'h470017005E, "hum71");
        send_frame(40'h4100170058, "hum65");
        send_frame(40'h3C00170053, "hum60");
        send_frame(40'h028C806573, "d22vec");
        send_frame(40'h470017005E, "hum71b");

        @(negedge clk1M);
        reset_now("midrst");
        idle_chk(3);

        // Reset while a captured frame is in flight must discard it.
        @(negedge clk1M);
        HYM2   = 40'h2D00170044;
        mstate = 3'd3;
        @(negedge clk1M);
        @(negedge clk1M);
        reset_now("fsmrst");
        idle_chk(6);

        send_frame(40'h470017005E, "pre_stale");
        idle_chk(STALE + 5);
        send_frame(40'h2D00170044, "post_stale");

        for (int i = 0; i < 60; i++) begin
            send_frame(rand_frame(), "rand");
            idle_chk(int'($urandom_range(0, 5)));
        end

        for (int i = 0; i < 260; i++) send_frame(40'h2D00170045, "sat");
        check_val("sat_final", 32'(err_cnt), 32'd255);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
